// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the byte type and the default FIFO depth. The depth is shared by the
// tx FIFO and a future rx-side FIFO.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam int unsigned UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array for the UART FIFOs.
// Ports:
//   clk_i    - clock; writes take effect on the rising edge
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data, combinational from the array (asynchronous read)
// The contents have no reset.
module uart_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmit AXI-stream input, on the serial clock.
// It absorbs bursts of single-cycle write strobes and drains them under
// valid/ready flow control. A sticky overflow bit records dropped writes.
// Ports:
//   clk_i       - serial clock (serclk)
//   rst_ni      - asynchronous active-low reset
//   wr_en_i     - push strobe; one byte per cycle while not full
//   wr_data_i   - byte to push
//   full_o      - occupancy == DEPTH
//   m_tdata_o   - head-of-FIFO byte (input_axis_tdata)
//   m_tvalid_o  - FIFO not empty (input_axis_tvalid)
//   m_tready_i  - uart input_axis_tready
//   count_o     - occupancy, 0..DEPTH
//   overflow_o  - sticky; set when a write is dropped
//   clr_ovf_i   - synchronous clear of overflow_o
// DEPTH must be a power of two and at least 2.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_FIFO_DEPTH,
    parameter int unsigned WIDTH = BYTE_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    output logic                   full_o,
    output logic [WIDTH-1:0]       m_tdata_o,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    input  logic                   clr_ovf_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PtrOne = {{AW{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Both use pre-edge state only; m_tvalid_o never looks at m_tready_i.
    assign push = wr_en_i && !full;
    assign drop = wr_en_i && full;
    assign pop  = !empty && m_tready_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (m_tdata_o)
    );

    assign full_o     = full;
    assign m_tvalid_o = !empty;
    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue model updated each rising
// edge, a compare process on each falling edge, directed scenarios with
// literal expectations, and a randomized backpressure phase.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_ni;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full_o;
    logic [WIDTH-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic [4:0]       count_o;
    logic             overflow_o;
    logic             clr_ovf;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .full_o     (full_o),
        .m_tdata_o  (m_tdata),
        .m_tvalid_o (m_tvalid),
        .m_tready_i (m_tready),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .clr_ovf_i  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: byte queue, sticky flag, drop counter, pop log.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] pop_log[$];
    bit               m_ovf = 1'b0;
    int               m_drops = 0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            bit was_full;
            was_full = (mq.size() == DEPTH);
            if (mq.size() != 0 && m_tready) pop_log.push_back(mq.pop_front());
            if (wr_en) begin
                if (was_full) begin
                    m_ovf = 1'b1;
                    m_drops++;
                end else begin
                    mq.push_back(wr_data);
                end
            end
            if (clr_ovf && !(wr_en && was_full)) m_ovf = 1'b0;
        end
    end

    // Compare every cycle, mid-way between rising edges.
    always @(negedge clk) begin
        chk("count", 32'(count_o), mq.size());
        chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
        chk("tvalid", 32'(m_tvalid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("tdata", 32'(m_tdata), 32'(mq[0]));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        m_tready = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + WIDTH'(i);
            cyc();
        end
        wr_en = 1'b0;
    endtask

    task automatic drain_all();
        int budget;
        budget = 0;
        m_tready = 1'b1;
        while (m_tvalid && budget < 4 * DEPTH) begin
            cyc();
            budget++;
        end
        m_tready = 1'b0;
        chk("drain_timeout", 32'(budget < 4 * DEPTH), 32'd1);
    endtask

    int log_base;
    int max_cnt;
    int drops0;
    int dut_drops;
    int ptready;

    initial begin
        rst_ni  = 1'b0;
        wr_data = '0;
        idle();
        repeat (3) cyc();
        rst_ni = 1'b1;
        cyc();
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);

        // Single byte with stall, then release.
        push_n(1, 8'h41);
        chk("single_tvalid", 32'(m_tvalid), 32'd1);
        chk("single_tdata", 32'(m_tdata), 32'h41);
        chk("single_count", 32'(count_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("single_hold", 32'(m_tdata), 32'h41);
        end
        m_tready = 1'b1;
        cyc();
        m_tready = 1'b0;
        chk("single_gone_tvalid", 32'(m_tvalid), 32'd0);
        chk("single_gone_count", 32'(count_o), 32'd0);

        // Fill, overflow, ordered drain, clear.
        push_n(16, 8'h00);
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_count", 32'(count_o), 32'd16);
        push_n(1, 8'hAA);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        chk("ovf_count", 32'(count_o), 32'd16);
        log_base = pop_log.size();
        drain_all();
        chk("drain_len", pop_log.size() - log_base, 32'd16);
        for (int i = 0; i < 16 && log_base + i < pop_log.size(); i++)
            chk("drain_order", 32'(pop_log[log_base + i]), i);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow_o), 32'd0);

        // Push while full with a pop in the same cycle.
        push_n(16, 8'h20);
        wr_en = 1'b1; wr_data = 8'hBB; m_tready = 1'b1;
        cyc();
        idle();
        chk("fullpop_ovf", 32'(overflow_o), 32'd1);
        chk("fullpop_count", 32'(count_o), 32'd15);
        push_n(1, 8'h30);
        clr_ovf = 1'b0;
        chk("refill_count", 32'(count_o), 32'd16);
        wr_en = 1'b1; wr_data = 8'hCC; clr_ovf = 1'b1;
        cyc();
        idle();
        chk("set_wins", 32'(overflow_o), 32'd1);

        // Reset asserted mid-cycle while full and overflowed.
        @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_count", 32'(count_o), 32'd0);
        chk("async_tvalid", 32'(m_tvalid), 32'd0);
        chk("async_full", 32'(full_o), 32'd0);
        chk("async_ovf", 32'(overflow_o), 32'd0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        // Simultaneous push and pop at count 5.
        push_n(5, 8'h50);
        wr_en = 1'b1; wr_data = 8'h55; m_tready = 1'b1;
        cyc();
        idle();
        chk("pushpop_count", 32'(count_o), 32'd5);
        drain_all();

        // Continuous streaming across the pointer wrap.
        log_base = pop_log.size();
        max_cnt  = 0;
        m_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h10 + 8'(i);
            cyc();
            if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
        end
        wr_en = 1'b0;
        repeat (3) cyc();
        m_tready = 1'b0;
        chk("stream_len", pop_log.size() - log_base, 32'd40);
        for (int i = 0; i < 40 && log_base + i < pop_log.size(); i++)
            chk("stream_order", 32'(pop_log[log_base + i]), 32'h10 + i);
        chk("stream_max_count", max_cnt, 32'd1);
        chk("stream_ovf", 32'(overflow_o), 32'd0);

        // Random bursts against random backpressure.
        drops0    = m_drops;
        dut_drops = 0;
        ptready   = 50;
        for (int c = 0; c < 1000; c++) begin
            if (c % 100 == 0) ptready = $urandom_range(10, 90);
            wr_en    = ($urandom_range(0, 3) != 0);
            wr_data  = 8'($urandom);
            m_tready = ($urandom_range(0, 99) < ptready);
            clr_ovf  = ($urandom_range(0, 31) == 0);
            if (wr_en && full_o) dut_drops++;
            cyc();
        end
        idle();
        chk("rand_drops", m_drops - drops0, dut_drops);
        drain_all();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
